// File: rtl/serial_bus_gatherer_pkg.sv
// Shared types and helpers for the serial-to-parallel word gatherer.
package serial_bus_gatherer_pkg;

  localparam int unsigned WORD_W = 4;

  // Width of the in-word bit counter for a given word width.
  function automatic int unsigned cnt_w(input int unsigned width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    LSB_FIRST = 1'b0,
    MSB_FIRST = 1'b1
  } bit_order_e;

endpackage

// File: rtl/serial_bus_gatherer_hold.sv
// One-entry valid/ready holding register for finished words.
module word_hold_reg #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             take_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Free the entry on take, then let a same-cycle load refill it.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (valid_q && take_i) begin
      valid_d = 1'b0;
    end
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  // Entry state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/serial_bus_gatherer.sv
// Gathers a serial bit stream into WIDTH-bit words with a one-word output buffer.
module serial_bus_gatherer #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             ser_data,
  input  logic                                             ser_valid,
  output logic                                             ser_ready,
  input  logic                                             ser_sof,
  output logic [WIDTH-1:0]                                 bus_data,
  output logic                                             bus_valid,
  input  logic                                             bus_ready,
  output logic                                             last_bit,
  output logic                                             drop_pulse,
  output logic [serial_bus_gatherer_pkg::cnt_w(WIDTH)-1:0] bit_count
);

  import serial_bus_gatherer_pkg::*;

  localparam int unsigned CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
  localparam bit_order_e ORDER = MSB_FIRST ? serial_bus_gatherer_pkg::MSB_FIRST
                                           : serial_bus_gatherer_pkg::LSB_FIRST;

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_bit_q, last_bit_d;
  logic             drop_q, drop_d;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] sof_word;
  logic             accept;
  logic             at_last;
  logic             word_done;
  logic             hold_valid;
  logic [WIDTH-1:0] hold_data;

  // Stall only the final bit of a word when the held word cannot leave.
  always_comb begin
    at_last   = (cnt_q == LAST_IDX);
    ser_ready = !(hold_valid && !bus_ready && at_last);
  end

  // Shift direction chosen so the first bit lands at the stated end of the word.
  always_comb begin
    if (ORDER == serial_bus_gatherer_pkg::MSB_FIRST) begin
      shifted  = {shift_q[WIDTH-2:0], ser_data};
      sof_word = {{(WIDTH-1){1'b0}}, ser_data};
    end else begin
      shifted  = {ser_data, shift_q[WIDTH-1:1]};
      sof_word = {ser_data, {(WIDTH-1){1'b0}}};
    end
  end

  // Accept path: count, shift, start-of-frame restart and word completion.
  always_comb begin
    accept     = ser_valid && ser_ready;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    last_bit_d = last_bit_q;
    drop_d     = 1'b0;
    word_done  = 1'b0;
    if (accept) begin
      last_bit_d = ser_data;
      if (ser_sof) begin
        shift_d = sof_word;
        cnt_d   = CNT_W'(1);
        drop_d  = (cnt_q != '0);
      end else begin
        shift_d = shifted;
        if (at_last) begin
          cnt_d     = '0;
          word_done = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // Serial-side state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q    <= '0;
      cnt_q      <= '0;
      last_bit_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      last_bit_q <= last_bit_d;
      drop_q     <= drop_d;
    end
  end

  word_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk_i  (clk),
    .rst_i  (rst),
    .load_i (word_done),
    .data_i (shifted),
    .take_i (bus_ready),
    .valid_o(hold_valid),
    .data_o (hold_data)
  );

  assign bus_valid  = hold_valid;
  assign bus_data   = hold_data;
  assign last_bit   = last_bit_q;
  assign drop_pulse = drop_q;
  assign bit_count  = cnt_q;

endmodule

// File: tb/tb_serial_bus_gatherer.sv
// Directed and randomised checks of serial_bus_gatherer in both bit orders.
module tb_serial_bus_gatherer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ser_data = 1'b0;
  logic       ser_valid = 1'b0;
  logic       ser_sof = 1'b0;
  logic       bus_ready = 1'b1;

  logic       ser_ready_m, bus_valid_m, last_bit_m, drop_m;
  logic [3:0] bus_data_m;
  logic [1:0] cnt_m;
  logic       ser_ready_l, bus_valid_l, last_bit_l, drop_l;
  logic [3:0] bus_data_l;
  logic [1:0] cnt_l;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_bus_gatherer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .ser_data(ser_data), .ser_valid(ser_valid),
    .ser_ready(ser_ready_m), .ser_sof(ser_sof), .bus_data(bus_data_m),
    .bus_valid(bus_valid_m), .bus_ready(bus_ready), .last_bit(last_bit_m),
    .drop_pulse(drop_m), .bit_count(cnt_m)
  );

  serial_bus_gatherer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .ser_data(ser_data), .ser_valid(ser_valid),
    .ser_ready(ser_ready_l), .ser_sof(ser_sof), .bus_data(bus_data_l),
    .bus_valid(bus_valid_l), .bus_ready(bus_ready), .last_bit(last_bit_l),
    .drop_pulse(drop_l), .bit_count(cnt_l)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b, input logic sof);
    int unsigned n = 0;
    ser_valid = 1'b1;
    ser_data  = b;
    ser_sof   = sof;
    #1;
    while (!ser_ready_m && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("send_timeout", 32'(n), 32'd0);
    tick();
    ser_valid = 1'b0;
    ser_sof   = 1'b0;
  endtask

  function automatic logic [3:0] rev4(input logic [3:0] w);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = w[3-i];
    return r;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_valid_m"}, 32'(bus_valid_m), 32'd0);
    chk({tag, "_data_m"}, 32'(bus_data_m), 32'd0);
    chk({tag, "_last_m"}, 32'(last_bit_m), 32'd0);
    chk({tag, "_drop_m"}, 32'(drop_m), 32'd0);
    chk({tag, "_cnt_m"}, 32'(cnt_m), 32'd0);
    chk({tag, "_valid_l"}, 32'(bus_valid_l), 32'd0);
    chk({tag, "_data_l"}, 32'(bus_data_l), 32'd0);
  endtask

  initial begin
    logic [3:0] q[$];
    logic [3:0] mword;
    logic [3:0] held;
    logic [3:0] w;
    int unsigned mcnt;
    int unsigned words;
    int unsigned cyc;
    logic stable_pend;
    logic exp_ready;

    // Reset state
    #1;
    chk_zero("reset");
    chk("reset_ready", 32'(ser_ready_m), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Test 1/2: 1,0,1,1 with consumer always ready
    bus_ready = 1'b1;
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    chk("t1_not_yet_valid", 32'(bus_valid_m), 32'd0);
    send(1'b1, 1'b0);
    chk("t1_valid", 32'(bus_valid_m), 32'd1);
    chk("t1_data_m", 32'(bus_data_m), 32'hB);
    chk("t2_data_l", 32'(bus_data_l), 32'hD);
    chk("t1_last_bit", 32'(last_bit_m), 32'd1);
    chk("t1_cnt_wrap", 32'(cnt_m), 32'd0);
    tick();
    chk("t1_valid_one_cycle", 32'(bus_valid_m), 32'd0);

    // Test 3: consumer stalled, 1111 then 0000
    bus_ready = 1'b0;
    repeat (4) send(1'b1, 1'b0);
    chk("t3_first_valid", 32'(bus_valid_m), 32'd1);
    chk("t3_first_data", 32'(bus_data_m), 32'hF);
    repeat (3) send(1'b0, 1'b0);
    chk("t3_cnt3", 32'(cnt_m), 32'd3);
    ser_valid = 1'b1;
    ser_data  = 1'b0;
    #1;
    chk("t3_stall_ready", 32'(ser_ready_m), 32'd0);
    tick();
    tick();
    chk("t3_hold_valid", 32'(bus_valid_m), 32'd1);
    chk("t3_hold_data", 32'(bus_data_m), 32'hF);
    chk("t3_still_stalled", 32'(ser_ready_m), 32'd0);
    chk("t3_cnt_held", 32'(cnt_m), 32'd3);
    bus_ready = 1'b1;
    #1;
    chk("t3_ready_comb", 32'(ser_ready_m), 32'd1);
    tick();
    ser_valid = 1'b0;
    chk("t3_reload_valid", 32'(bus_valid_m), 32'd1);
    chk("t3_second_data_m", 32'(bus_data_m), 32'h0);
    chk("t3_second_data_l", 32'(bus_data_l), 32'h0);
    tick();
    chk("t3_drained", 32'(bus_valid_m), 32'd0);

    // Test 4: start-of-frame discards a partial word
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    send(1'b0, 1'b1);
    chk("t4_drop", 32'(drop_m), 32'd1);
    chk("t4_cnt1", 32'(cnt_m), 32'd1);
    send(1'b0, 1'b0);
    chk("t4_drop_once", 32'(drop_m), 32'd0);
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    chk("t4_data_m", 32'(bus_data_m), 32'h2);
    chk("t4_data_l", 32'(bus_data_l), 32'h4);
    chk("t4_valid", 32'(bus_valid_m), 32'd1);
    send(1'b1, 1'b1);
    chk("t4_sof_at0_nodrop", 32'(drop_m), 32'd0);
    chk("t4_sof_at0_cnt", 32'(cnt_m), 32'd1);
    send(1'b0, 1'b0);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    chk("t4_sof_word_m", 32'(bus_data_m), 32'h9);
    chk("t4_sof_word_l", 32'(bus_data_l), 32'h9);

    // Test 5: asynchronous reset mid-word and with a held word
    tick();
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    chk("t5_cnt3", 32'(cnt_m), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("t5_rst_mid");
    @(negedge clk);
    rst = 1'b0;
    tick();
    bus_ready = 1'b0;
    repeat (4) send(1'b1, 1'b0);
    chk("t5_held", 32'(bus_valid_m), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("t5_rst_held");
    chk("t5_ready_after_rst", 32'(ser_ready_m), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    tick();
    bus_ready = 1'b1;
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    chk("t5_clean_valid", 32'(bus_valid_m), 32'd1);
    chk("t5_clean_m", 32'(bus_data_m), 32'h7);
    chk("t5_clean_l", 32'(bus_data_l), 32'hE);
    tick();
    chk("t5_clean_drained", 32'(bus_valid_m), 32'd0);

    // Test 6: random valid/ready against a word scoreboard
    mword = '0;
    held = '0;
    mcnt = 0;
    words = 0;
    cyc = 0;
    stable_pend = 1'b0;
    while (words < 1000 && cyc < 60000) begin
      ser_valid = 1'($urandom_range(0, 1));
      ser_data  = 1'($urandom_range(0, 1));
      bus_ready = 1'($urandom_range(0, 1));
      ser_sof   = 1'b0;
      #1;
      if (stable_pend) begin
        chk("t6_stable_valid", 32'(bus_valid_m), 32'd1);
        chk("t6_stable_data", 32'(bus_data_m), 32'(held));
      end
      exp_ready = !(bus_valid_m && !bus_ready && mcnt == 3);
      chk("t6_ser_ready", 32'(ser_ready_m), 32'(exp_ready));
      if (bus_valid_m && bus_ready) begin
        if (q.size() == 0) begin
          chk("t6_unexpected_word", 32'(bus_data_m), 32'hFFFF_FFFF);
        end else begin
          w = q.pop_front();
          chk("t6_word_m", 32'(bus_data_m), 32'(w));
          chk("t6_word_l", 32'(bus_data_l), 32'(rev4(w)));
        end
        words++;
      end
      stable_pend = bus_valid_m && !bus_ready;
      held = bus_data_m;
      if (ser_valid && exp_ready) begin
        mword = {mword[2:0], ser_data};
        mcnt++;
        if (mcnt == 4) begin
          q.push_back(mword);
          mcnt = 0;
        end
      end
      tick();
      cyc++;
    end
    ser_valid = 1'b0;
    chk("t6_word_total", 32'(words), 32'd1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
